// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity codes,
// transmitter state encoding and the parity helper.
package uart_tx_fifo_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BREAK    = 3'd5,
    S_BRK_STOP = 3'd6
  } tx_state_t;

  // Data is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic calc_parity(input logic [8:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Single-clock FIFO with occupancy count. Read data is taken straight from the
// storage array at the read pointer, so the head word is valid in the pop cycle.
module uart_tx_fifo_param_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and count; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO and break generation.
//
//   state      | meaning
//   S_IDLE     | line high, waiting for data or break request
//   S_START    | start bit (low)
//   S_DATA     | data bits, LSB first
//   S_PARITY   | parity bit (only when PARITY != none)
//   S_STOP     | stop bit(s), high; may chain straight into the next START
//   S_BREAK    | line held low while tx_break is asserted
//   S_BRK_STOP | one bit time high after a break, then idle
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic                 tx_break,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 tdo
);

  tx_state_t              state;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   tmr;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   tick;
  logic                   last_data;
  logic                   last_stop;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [8:0]             rd_ext;

  uart_tx_fifo_param_sync_fifo #(
    .DW (DATA_BITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready  = !fifo_full;
  assign busy      = (state != S_IDLE);
  assign tick      = (tmr == div_q);
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign rd_ext    = 9'(fifo_rdata);

  // Pop from idle, or from the final stop tick to chain frames without a gap;
  // a pending break wins over queued data.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !tx_break) begin
      if (state == S_IDLE)                           pop = 1'b1;
      else if (state == S_STOP && tick && last_stop) pop = 1'b1;
    end
  end

  // Transmit FSM with bit timer, bit counter, shift register and registered tdo.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tdo     <= 1'b1;
      tx_done <= 1'b0;
      div_q   <= '0;
      tmr     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tmr     <= tick ? '0 : tmr + DIV_WIDTH'(1);
      case (state)
        S_IDLE: begin
          tmr <= '0;
          if (tx_break) begin
            state <= S_BREAK;
            tdo   <= 1'b0;
          end else if (pop) begin
            state   <= S_START;
            tdo     <= 1'b0;
            shreg   <= fifo_rdata;
            par_bit <= calc_parity(rd_ext, PARITY);
            div_q   <= baud_div;
          end
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            tdo     <= shreg[0];
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (last_data) begin
              bit_cnt <= '0;
              if (PARITY != PAR_NONE) begin
                state <= S_PARITY;
                tdo   <= par_bit;
              end else begin
                state <= S_STOP;
                tdo   <= 1'b1;
              end
            end else begin
              shreg   <= shreg >> 1;
              tdo     <= shreg[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state   <= S_STOP;
            tdo     <= 1'b1;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (last_stop) begin
              tx_done <= 1'b1;
              if (pop) begin
                state   <= S_START;
                tdo     <= 1'b0;
                shreg   <= fifo_rdata;
                par_bit <= calc_parity(rd_ext, PARITY);
                div_q   <= baud_div;
              end else begin
                state <= S_IDLE;
                tdo   <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_BREAK: begin
          tmr <= '0;
          if (!tx_break) begin
            state <= S_BRK_STOP;
            tdo   <= 1'b1;
            div_q <= baud_div;
          end
        end
        S_BRK_STOP: begin
          if (tick) begin
            state <= S_IDLE;
            tdo   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tdo   <= 1'b1;
        end
      endcase
    end
  end

endmodule
